// File: rtl/store_buffer_rv32i.sv
// store_buffer_rv32i: lane-aligns stores into 16-byte lines and queues them for the data-memory write port.
// Optional macro STORE_BUFFER_MERGE_EN: merge a store into the tail entry when it hits the same line.
module store_buffer_rv32i #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [127:0]             in_data,
  input  logic [15:0]              in_byte_en,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [127:0]             mem_data,
  output logic [15:0]              mem_byte_en,
  input  logic                     flush,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     misalign_err
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [127:0]      data_q [DEPTH];
  logic [15:0]       en_q   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [3:0]        off;
  logic [31:0]       en_wide;
  logic [15:0]       sh_en;
  logic [127:0]      sh_data;
  logic [ADDR_W-1:0] line;
  logic              mis, accept, live, merge, push, pop;

  assign off     = in_addr[3:0];
  assign en_wide = {16'b0, in_byte_en} << off;
  assign sh_en   = en_wide[15:0];
  assign sh_data = in_data << {off, 3'b000};
  assign line    = {in_addr[ADDR_W-1:4], 4'b0000};
  assign mis     = |en_wide[31:16];
  assign live    = |in_byte_en && !mis;

  assign in_ready = (32'(count) < DEPTH) && !flush;
  assign accept   = in_valid && in_ready;
  assign empty    = (count == '0);
  assign mem_valid = !empty;
  assign pop      = mem_valid && mem_ready;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PW-1:0] tail;
  assign tail  = wr_ptr - 1'b1;
  // The tail differs from the head only when two or more entries are held.
  assign merge = accept && live && (32'(count) >= 2) && (addr_q[tail] == line);
`else
  assign merge = 1'b0;
`endif

  assign push = accept && live && !merge;

  assign mem_addr    = addr_q[rd_ptr];
  assign mem_data    = data_q[rd_ptr];
  assign mem_byte_en = en_q[rd_ptr];

  // Queue storage, pointers, occupancy and the misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        en_q[i]   <= '0;
      end
    end else begin
      misalign_err <= accept && mis;
      if (push) begin
        addr_q[wr_ptr] <= line;
        data_q[wr_ptr] <= sh_data;
        en_q[wr_ptr]   <= sh_en;
        wr_ptr         <= wr_ptr + 1'b1;
      end
`ifdef STORE_BUFFER_MERGE_EN
      if (merge) begin
        en_q[tail] <= en_q[tail] | sh_en;
        for (int b = 0; b < 16; b++)
          if (sh_en[b]) data_q[tail][8*b +: 8] <= sh_data[8*b +: 8];
      end
`endif
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule
